// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between video_timing_gen (master) and its consumers (slave).
// The consumer owns the clock enable; everything else flows out of the generator.
interface video_timing_gen_if;
  logic        en;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    input  en,
    output x, y, hsync, vsync, de, line_start, frame_start, frame_cnt
  );

  modport slave (
    output en,
    input  x, y, hsync, vsync, de, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parameterised raster timing generator: undelayed x/y counters plus sync/DE/strobes
// delayed by 1+DELAY cycles. Define VTG_FRAME_CNT_EN to build the 16-bit frame counter.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int DELAY    = 1
) (
  input  logic                pixclk,
  input  logic                rst_n,
  video_timing_gen_if.master  vid
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic       H_ACT_LVL = (H_POL != 0);
  localparam logic       V_ACT_LVL = (V_POL != 0);

  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("video_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("video_timing_gen: V_TOTAL exceeds 1024");
  end
  if (DELAY < 0 || DELAY > 15) begin : g_bad_delay
    $error("video_timing_gen: DELAY must be 0..15");
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } tim_t;

  localparam tim_t TIM_IDLE = '{hs: ~H_ACT_LVL, vs: ~V_ACT_LVL, de: 1'b0, ls: 1'b0, fs: 1'b0};

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  tim_t       tim_d;
  tim_t       pipe_q [0:DELAY];

  // Raster counters: y only advances on the x wrap.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (vid.en) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Decode of the current coordinate; registered into pipe_q[0].
  always_comb begin
    tim_d    = TIM_IDLE;
    tim_d.de = ({1'b0, x_q} < 11'(H_ACTIVE)) && ({1'b0, y_q} < 11'(V_ACTIVE));
    tim_d.hs = (({1'b0, x_q} >= 11'(HS_START)) && ({1'b0, x_q} < 11'(HS_END)))
               ? H_ACT_LVL : ~H_ACT_LVL;
    tim_d.vs = (({1'b0, y_q} >= 11'(VS_START)) && ({1'b0, y_q} < 11'(VS_END)))
               ? V_ACT_LVL : ~V_ACT_LVL;
    tim_d.ls = (x_q == 10'd0);
    tim_d.fs = (x_q == 10'd0) && (y_q == 10'd0);
  end

  // Stage 0 plus DELAY further stages; en freezes the whole line so pulses never stretch.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= DELAY; i++) begin
        pipe_q[i] <= TIM_IDLE;
      end
    end else if (vid.en) begin
      pipe_q[0] <= tim_d;
      for (int i = 1; i <= DELAY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.hsync       = pipe_q[DELAY].hs;
  assign vid.vsync       = pipe_q[DELAY].vs;
  assign vid.de          = pipe_q[DELAY].de;
  assign vid.line_start  = pipe_q[DELAY].ls;
  assign vid.frame_start = pipe_q[DELAY].fs;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        fs_next;

  // Look one stage ahead so the count changes on the same edge frame_start appears.
  if (DELAY == 0) begin : g_fs_next_d0
    assign fs_next = tim_d.fs;
  end else begin : g_fs_next_dn
    assign fs_next = pipe_q[DELAY-1].fs;
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vid.en && fs_next) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vid.frame_cnt = frame_cnt_q;
`else
  assign vid.frame_cnt = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised-enable bench for video_timing_gen: three configurations checked every cycle
// against an arithmetic raster model, plus per-frame DE/sync/period totals.
module tb_video_timing_gen;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int hpol; int vpol; int dly;
  } cfg_t;

  typedef struct {
    longint x; longint y;
    bit hs; bit vs; bit de; bit ls; bit fs;
    longint fc;
  } exp_t;

  // Small rasters so full frames fit the run; the third is the full 640x480 default.
  localparam cfg_t CFG_A = '{8, 2, 3, 2, 5, 1, 2, 1, 0, 0, 1};
  localparam cfg_t CFG_B = '{6, 1, 2, 3, 4, 2, 1, 2, 1, 1, 0};
  localparam cfg_t CFG_C = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1};

  logic pixclk = 1'b0;
  logic rst_n;
  logic en;

  video_timing_gen_if vid_a ();
  video_timing_gen_if vid_b ();
  video_timing_gen_if vid_c ();

  assign vid_a.en = en;
  assign vid_b.en = en;
  assign vid_c.en = en;

  video_timing_gen #(
    .H_ACTIVE(CFG_A.ha), .H_FP(CFG_A.hfp), .H_SYNC(CFG_A.hs), .H_BP(CFG_A.hbp),
    .V_ACTIVE(CFG_A.va), .V_FP(CFG_A.vfp), .V_SYNC(CFG_A.vs), .V_BP(CFG_A.vbp),
    .H_POL(CFG_A.hpol), .V_POL(CFG_A.vpol), .DELAY(CFG_A.dly)
  ) dut_a (.pixclk(pixclk), .rst_n(rst_n), .vid(vid_a));

  video_timing_gen #(
    .H_ACTIVE(CFG_B.ha), .H_FP(CFG_B.hfp), .H_SYNC(CFG_B.hs), .H_BP(CFG_B.hbp),
    .V_ACTIVE(CFG_B.va), .V_FP(CFG_B.vfp), .V_SYNC(CFG_B.vs), .V_BP(CFG_B.vbp),
    .H_POL(CFG_B.hpol), .V_POL(CFG_B.vpol), .DELAY(CFG_B.dly)
  ) dut_b (.pixclk(pixclk), .rst_n(rst_n), .vid(vid_b));

  video_timing_gen #(
    .H_ACTIVE(CFG_C.ha), .H_FP(CFG_C.hfp), .H_SYNC(CFG_C.hs), .H_BP(CFG_C.hbp),
    .V_ACTIVE(CFG_C.va), .V_FP(CFG_C.vfp), .V_SYNC(CFG_C.vs), .V_BP(CFG_C.vbp),
    .H_POL(CFG_C.hpol), .V_POL(CFG_C.vpol), .DELAY(CFG_C.dly)
  ) dut_c (.pixclk(pixclk), .rst_n(rst_n), .vid(vid_c));

  // Clock / reset
  always #5 pixclk = ~pixclk;

  int     n_cmp;
  int     n_bad;
  longint k;              // enabled edges since reset release
  longint fc_off [3];
  int     period [3];
  int     de_cnt [3];
  int     hs_cnt [3];
  int     vs_cnt [3];
  bit     have_prev [3];

  task automatic check_eq(input string tag, input longint obs, input longint expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic cfg_t cfg_of(input int c);
    case (c)
      0:       return CFG_A;
      1:       return CFG_B;
      default: return CFG_C;
    endcase
  endfunction

  // Output at enabled cycle k reflects the coordinate reached at cycle k-1-DELAY.
  function automatic exp_t model(input cfg_t cf, input longint kk, input longint off);
    exp_t   m;
    longint ht = cf.ha + cf.hfp + cf.hs + cf.hbp;
    longint vt = cf.va + cf.vfp + cf.vs + cf.vbp;
    longint ft = ht * vt;
    longint j, jx, jy;
    m.x  = kk % ht;
    m.y  = (kk / ht) % vt;
    m.hs = (cf.hpol == 0);
    m.vs = (cf.vpol == 0);
    m.de = 1'b0;
    m.ls = 1'b0;
    m.fs = 1'b0;
    m.fc = off;
    if (kk >= 1 + cf.dly) begin
      j  = kk - 1 - cf.dly;
      jx = j % ht;
      jy = (j / ht) % vt;
      m.de = (jx < cf.ha) && (jy < cf.va);
      if (jx >= cf.ha + cf.hfp && jx < cf.ha + cf.hfp + cf.hs) m.hs = (cf.hpol != 0);
      if (jy >= cf.va + cf.vfp && jy < cf.va + cf.vfp + cf.vs) m.vs = (cf.vpol != 0);
      m.ls = (jx == 0);
      m.fs = (jx == 0) && (jy == 0);
      m.fc = (off + j / ft + 1) % 65536;
    end
`ifndef VTG_FRAME_CNT_EN
    m.fc = 0;
`endif
    return m;
  endfunction

  task automatic clear_model();
    k = 0;
    for (int c = 0; c < 3; c++) begin
      fc_off[c]    = 0;
      period[c]    = 0;
      de_cnt[c]    = 0;
      hs_cnt[c]    = 0;
      vs_cnt[c]    = 0;
      have_prev[c] = 1'b0;
    end
  endtask

  // Scoreboard for one instance: per-cycle model compare plus per-frame totals.
  task automatic check_dut(input int c, input logic [9:0] ox, input logic [9:0] oy,
                           input logic ohs, input logic ovs, input logic ode,
                           input logic ols, input logic ofs, input logic [15:0] ofc,
                           input bit adv);
    cfg_t   cf = cfg_of(c);
    exp_t   m  = model(cf, k, fc_off[c]);
    longint ht = cf.ha + cf.hfp + cf.hs + cf.hbp;
    longint vt = cf.va + cf.vfp + cf.vs + cf.vbp;
    check_eq($sformatf("c%0d_x", c), ox, m.x);
    check_eq($sformatf("c%0d_y", c), oy, m.y);
    check_eq($sformatf("c%0d_hsync", c), ohs, m.hs);
    check_eq($sformatf("c%0d_vsync", c), ovs, m.vs);
    check_eq($sformatf("c%0d_de", c), ode, m.de);
    check_eq($sformatf("c%0d_line_start", c), ols, m.ls);
    check_eq($sformatf("c%0d_frame_start", c), ofs, m.fs);
    check_eq($sformatf("c%0d_frame_cnt", c), ofc, m.fc);
    if (adv) begin
      if (ofs) begin
        if (have_prev[c]) begin
          check_eq($sformatf("c%0d_frame_period", c), period[c], ht * vt);
          check_eq($sformatf("c%0d_de_per_frame", c), de_cnt[c], cf.ha * cf.va);
          check_eq($sformatf("c%0d_hs_per_frame", c), hs_cnt[c], cf.hs * vt);
          check_eq($sformatf("c%0d_vs_per_frame", c), vs_cnt[c], cf.vs * ht);
        end
        have_prev[c] = 1'b1;
        period[c] = 0;
        de_cnt[c] = 0;
        hs_cnt[c] = 0;
        vs_cnt[c] = 0;
      end
      period[c]++;
      if (ode) de_cnt[c]++;
      if (ohs == (cf.hpol != 0)) hs_cnt[c]++;
      if (ovs == (cf.vpol != 0)) vs_cnt[c]++;
    end
  endtask

  task automatic check_all(input bit adv);
    check_dut(0, vid_a.x, vid_a.y, vid_a.hsync, vid_a.vsync, vid_a.de,
              vid_a.line_start, vid_a.frame_start, vid_a.frame_cnt, adv);
    check_dut(1, vid_b.x, vid_b.y, vid_b.hsync, vid_b.vsync, vid_b.de,
              vid_b.line_start, vid_b.frame_start, vid_b.frame_cnt, adv);
    check_dut(2, vid_c.x, vid_c.y, vid_c.hsync, vid_c.vsync, vid_c.de,
              vid_c.line_start, vid_c.frame_start, vid_c.frame_cnt, adv);
  endtask

  // Driver: random enable with low runs of 1..7 cycles, one mid-run async reset.
  initial begin
    bit adv;
    bit force_pending;
    int low_run;
    int rst_hold;
    n_cmp         = 0;
    n_bad         = 0;
    low_run       = 0;
    rst_hold      = 0;
    force_pending = 1'b0;
    rst_n         = 1'b0;
    en            = 1'b0;
    clear_model();
    repeat (3) @(negedge pixclk);
    check_all(1'b0);
    rst_n = 1'b1;
    en    = 1'b1;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      adv = rst_n && en;
      if (adv) k++;
      @(negedge pixclk);
`ifdef VTG_FRAME_CNT_EN
      if (force_pending) begin
        release dut_a.frame_cnt_q;
        release dut_b.frame_cnt_q;
        release dut_c.frame_cnt_q;
        force_pending = 1'b0;
      end
`endif
      check_all(adv);

      if (cyc == 2500) begin
        rst_n = 1'b0;
        clear_model();
        #1;
        check_all(1'b0);
        rst_hold = 2;
        en = 1'(($urandom_range(0, 1)));
      end else if (rst_hold > 0) begin
        rst_hold--;
        en = 1'b1;
        if (rst_hold == 0) begin
          rst_n = 1'b1;
`ifdef VTG_FRAME_CNT_EN
          en = 1'b0;
          force dut_a.frame_cnt_q = 16'd65534;
          force dut_b.frame_cnt_q = 16'd65534;
          force dut_c.frame_cnt_q = 16'd65534;
          for (int c = 0; c < 3; c++) fc_off[c] = 65534;
          force_pending = 1'b1;
`endif
        end
      end else if (low_run > 0) begin
        low_run--;
        en = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        low_run = $urandom_range(0, 6);
        en = 1'b0;
      end else begin
        en = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
